// File: rtl/stopwatch_lap_counter.sv
// Stopwatch MM:SS BCD time base with lap-hold display; `STOPWATCH_SATURATE_EN holds the count at 59:59 instead of wrapping.
// Latency: display trails the live count by 1 cycle; no backpressure, memory=1 freezes the display while counting continues.
module stopwatch_lap_counter #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_pulse,
  input  logic       clr_pulse,
  input  logic       memory,
  output logic       running,
  output logic       tick,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  bcd_time_t       live_q, live_d;
  bcd_time_t       disp_q, disp_d;

  function automatic bcd_time_t bcd_next(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t == bcd_time_t'(16'h5959)) begin
`ifdef STOPWATCH_SATURATE_EN
      n = t;
`else
      n = '0;
`endif
    end else if (t.sec_ones != 4'd9) begin
      n.sec_ones = t.sec_ones + 4'd1;
    end else begin
      n.sec_ones = 4'd0;
      if (t.sec_tens != 4'd5) begin
        n.sec_tens = t.sec_tens + 4'd1;
      end else begin
        n.sec_tens = 4'd0;
        if (t.min_ones != 4'd9) begin
          n.min_ones = t.min_ones + 4'd1;
        end else begin
          n.min_ones = 4'd0;
          n.min_tens = t.min_tens + 4'd1;
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    live_d  = live_q;
    disp_d  = memory ? disp_q : live_q;
    tick    = (state_q == RUN) && (pre_q == PRE_MAX);

    if (run_pulse) begin
      state_d = (state_q == RUN) ? STOP : RUN;
    end

    if (state_q == RUN) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        live_d = bcd_next(live_q);
      end
    end else if (clr_pulse) begin
      // Clear overrides the lap hold so the operator always sees 00:00.
      pre_d  = '0;
      live_d = '0;
      disp_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STOP;
      pre_q   <= '0;
      live_q  <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      live_q  <= live_d;
      disp_q  <= disp_d;
    end
  end

  assign running  = (state_q == RUN);
  assign min_tens = disp_q.min_tens;
  assign min_ones = disp_q.min_ones;
  assign sec_tens = disp_q.sec_tens;
  assign sec_ones = disp_q.sec_ones;

endmodule
